// File: rtl/dt_res_packer.sv
`timescale 1ns/1ps
// dt_res_packer: thresholds the 8-bit result RAM into 1-bit pixels, packs 16 per word MSB first, counts ones
module dt_res_packer #(
  parameter int RES_AW = 14,
  parameter int PK_AW  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        thr,
  output logic              res_rd,
  output logic [RES_AW-1:0] res_addr,
  input  logic [7:0]        res_di,
  output logic              pk_wr,
  output logic [PK_AW-1:0]  pk_addr,
  output logic [15:0]       pk_do,
  output logic              busy,
  output logic              done,
  output logic [RES_AW:0]   ones_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t             st;
  logic [7:0]         thr_q;
  logic [15:0]        sh;
  logic [3:0]         bc;
  logic [PK_AW-1:0]   wc;
  logic               b;
  assign b = res_di >= thr_q;
  // pass sequencer: issue reads, capture the pixel read one cycle earlier, emit a word every 16 pixels
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st       <= IDLE;
      thr_q    <= '0;
      sh       <= '0;
      bc       <= '0;
      wc       <= '0;
      res_rd   <= 1'b0;
      res_addr <= '0;
      pk_wr    <= 1'b0;
      pk_addr  <= '0;
      pk_do    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ones_cnt <= '0;
    end else begin
      pk_wr <= 1'b0;
      done  <= 1'b0;
      if (st == RUN || st == FLUSH) begin
        sh       <= {sh[14:0], b};
        bc       <= bc + 4'd1;
        ones_cnt <= ones_cnt + {{RES_AW{1'b0}}, b};
        if (bc == 4'd15) begin
          pk_wr   <= 1'b1;
          pk_addr <= wc;
          pk_do   <= {sh[14:0], b};
          wc      <= wc + 1'b1;
        end
      end
      case (st)
        IDLE: if (start) begin
          thr_q    <= thr;
          sh       <= '0;
          bc       <= '0;
          wc       <= '0;
          ones_cnt <= '0;
          res_rd   <= 1'b1;
          res_addr <= '0;
          busy     <= 1'b1;
          st       <= RUN;
        end
        RUN: begin
          res_addr <= res_addr + 1'b1;
          if (res_addr == {{(RES_AW-1){1'b1}}, 1'b0}) st <= FLUSH;
        end
        FLUSH: begin
          res_rd <= 1'b0;
          st     <= DONE;
        end
        DONE: begin
          busy <= 1'b0;
          done <= 1'b1;
          st   <= IDLE;
        end
      endcase
    end
endmodule

// File: doc/dt_res_packer.md
# dt_res_packer

Post-processing block for the distance-transform datapath. It reads the 8-bit-per-pixel result RAM (128x128 = 16384 pixels) through the `res_*` read port and thresholds each pixel to one bit. It packs 16 bits per word, MSB first, and writes the words into a 1024x16 packed-image memory, which has the same layout as the sti ROM. It is the packing counterpart of the DT core's unpacking of sti words, and it also reports the count of set pixels.

## Interface

Parameters:
- `RES_AW`, default 14: result RAM address width (pixel count = 2^RES_AW).
- `PK_AW`, default 10: packed memory address width; must equal `RES_AW-4`.

Ports:
- `clk`  in  1  single clock; all flops on posedge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `start`  in  1  sampled in IDLE only; a 1 begins a pass.
- `thr`  in  8  threshold, sampled on the `start` edge; a pixel becomes 1 iff pixel >= `thr` (unsigned).
- `res_rd`  out  1  result RAM read enable.
- `res_addr`  out  RES_AW  result RAM pixel address.
- `res_di`  in  8  result RAM read data. The RAM samples at negedge and the data is captured at the following posedge.
- `pk_wr`  out  1  packed memory write enable; the memory writes on the posedge where `pk_wr`=1.
- `pk_addr`  out  PK_AW  packed word address.
- `pk_do`  out  16  packed word; bit 15 is pixel 16k, bit 0 is pixel 16k+15.
- `busy`  out  1  high from RUN entry through FLUSH.
- `done`  out  1  one-cycle pulse at end of pass.
- `ones_cnt`  out  RES_AW+1  number of 1 pixels in the last pass; valid from `done` until the next `start`.

## Operation

- All outputs are registered. Reset value is 0 for every output, and the FSM resets to IDLE.
- FSM states:
  - IDLE: `busy`=0. On `start`=1, latch `thr`, clear the shift register, bit counter and `ones_cnt`, drive `res_rd`=1 and `res_addr`=0, then go to RUN.
  - RUN: each cycle, increment `res_addr` and capture `res_di` for the address issued the previous cycle.
    - A compare result of 1 increments `ones_cnt` (saturation impossible at this width).
    - The compare bit shifts into the 16-bit shift register from the LSB.
    - On every 16th captured pixel, drive `pk_wr`=1, `pk_addr`=word index and `pk_do`={shift[14:0], new bit}.
    - After driving `res_addr`=2^RES_AW-1, go to FLUSH with `res_rd`=0.
  - FLUSH: capture the final pixel and issue the final word write, then go to DONE.
  - DONE: `done`=1 and `pk_wr`=0, then go to IDLE.
- `pk_wr` is high for exactly one cycle per word, and words are written strictly in order 0..2^PK_AW-1.
- `start` outside IDLE is ignored, and `thr` changes after the start edge have no effect.
- When `reset` is asserted mid-pass, outputs return to 0 at once and the FSM returns to IDLE. Words already written remain in memory, and the next pass rewrites all of them.
- `res_addr` and `pk_addr` do not wrap within a pass, and both hold their last values while idle.

## Timing

- Let t0 be the posedge sampling `start`=1 in IDLE.
- The `res_addr`=n read is driven after edge t0+n, and pixel n is captured at t0+n+1.
- Word k (`pk_wr`, `pk_addr`=k, `pk_do`) is driven after t0+16k+16 and written at t0+16k+17.
- `res_rd` is high after t0 through t0+2^RES_AW-1 and low after t0+2^RES_AW.
- The last word is driven after t0+16384 (default sizes). `done` is high for the cycle after t0+16385.
- `busy` is high after t0 through t0+16384.
- A new `start` is accepted no earlier than the edge ending the `done` cycle (t0+16386). Total pass is 16386 cycles.

## Test plan

- Result RAM all 0, `thr`=1: all 1024 words = 0x0000, `ones_cnt`=0, and `done` pulses once exactly 16386 cycles after start.
- `res_M[i]`=i[7:0], `thr`=128: word k = 0xFFFF when (k mod 16)>=8, else 0x0000. `ones_cnt`=8192.
- Only `res_M[17]`=5, `thr`=5: word 1 = 0x4000, all others 0x0000, `ones_cnt`=1. Repeat with `thr`=6: all 0x0000, `ones_cnt`=0.
- `thr`=0, any contents: all words 0xFFFF and `ones_cnt`=16384. Also check that `pk_wr` pulses occur exactly every 16 cycles.
- Assert `reset` low at cycle 5000 of a pass: all outputs 0 immediately. After release plus `start`, the full pass produces correct words and `ones_cnt`.
- Toggle `start` and `thr` during RUN: no restart, results use the `thr` latched at t0, and a single `done` pulse.
